// File: rtl/ibex_rf_wb_arbiter.sv
// Write-back arbiter and pending-register scoreboard for the single write
// port of the flip-flop register file. LSU has fixed priority over EX, with a
// starvation counter that forces an EX win after StarveLimit blocked cycles.
// The winning write is registered; the scoreboard tracks issued-but-unwritten
// destinations and stalls ID reads of them until the register file holds the
// new value.
module ibex_rf_wb_arbiter #(
    parameter int RV32E       = 0,
    parameter int DataWidth   = 32,
    parameter int StarveLimit = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 ex_valid_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,

    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_ready_o,

    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,

    input  logic                 issue_valid_i,
    input  logic [4:0]           issue_waddr_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 stall_o
);

    localparam logic [3:0] STARVE_MAX = 4'(StarveLimit);

    // In RV32E mode bit 4 of every register address is ignored.
    function automatic logic [4:0] eff_addr(input logic [4:0] a);
        if (RV32E != 0) begin
            return {1'b0, a[3:0]};
        end
        return a;
    endfunction

    logic [3:0]           starve_cnt;
    logic                 ex_grant;
    logic                 lsu_grant;
    logic [4:0]           win_addr;
    logic [DataWidth-1:0] win_data;
    logic [31:0]          pending;
    logic [31:0]          pending_next;
    logic [4:0]           issue_addr;
    logic [4:0]           raddr_a;
    logic [4:0]           raddr_b;

    assign issue_addr = eff_addr(issue_waddr_i);
    assign raddr_a    = eff_addr(raddr_a_i);
    assign raddr_b    = eff_addr(raddr_b_i);

    // Grant selection: LSU wins unless EX has been starved up to the limit.
    always_comb begin
        ex_grant  = ex_valid_i && (!lsu_valid_i || (starve_cnt >= STARVE_MAX));
        lsu_grant = lsu_valid_i && !ex_grant;
        win_addr  = ex_grant ? eff_addr(ex_waddr_i) : eff_addr(lsu_waddr_i);
        win_data  = ex_grant ? ex_wdata_i : lsu_wdata_i;
    end

    assign ex_ready_o  = ex_grant;
    assign lsu_ready_o = lsu_grant;

    // Count consecutive cycles in which a waiting EX request lost; saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= 4'd0;
        end else if (!ex_valid_i || ex_grant) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt < STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Registered write port; a granted write to x0 is acknowledged but not performed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= 5'd0;
            rf_wdata_o <= '0;
        end else if (ex_grant || lsu_grant) begin
            rf_we_o    <= (win_addr != 5'd0);
            rf_waddr_o <= win_addr;
            rf_wdata_o <= win_data;
        end else begin
            rf_we_o    <= 1'b0;
        end
    end

    // Next pending set: clear the register being written, then apply the new
    // issue so that a same-edge re-issue keeps the register pending.
    always_comb begin
        pending_next = pending;
        if (rf_we_o) begin
            pending_next[rf_waddr_o] = 1'b0;
        end
        if (issue_valid_i && (issue_addr != 5'd0)) begin
            pending_next[issue_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending <= 32'd0;
        end else begin
            pending <= pending_next;
        end
    end

    assign stall_o = pending[raddr_a] | pending[raddr_b];

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Self-checking bench: two instances (RV32 and RV32E) share one stimulus
// stream; a behavioural model predicts every output each cycle, and directed
// sequences pin hand-computed values.
module tb_ibex_rf_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        issue_valid_i;
    logic [4:0]  issue_waddr_i;
    logic [4:0]  raddr_a_i;
    logic [4:0]  raddr_b_i;

    logic        ex_ready0, lsu_ready0, we0, stall0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        ex_ready1, lsu_ready1, we1, stall1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_rf_wb_arbiter #(.RV32E(0), .DataWidth(32), .StarveLimit(LIMIT)) dut0 (
        .clk_i(clk), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(ex_ready0),
        .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_ready_o(lsu_ready0),
        .rf_we_o(we0), .rf_waddr_o(waddr0), .rf_wdata_o(wdata0),
        .issue_valid_i(issue_valid_i), .issue_waddr_i(issue_waddr_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .stall_o(stall0)
    );

    ibex_rf_wb_arbiter #(.RV32E(1), .DataWidth(32), .StarveLimit(LIMIT)) dut1 (
        .clk_i(clk), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(ex_ready1),
        .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_ready_o(lsu_ready1),
        .rf_we_o(we1), .rf_waddr_o(waddr1), .rf_wdata_o(wdata1),
        .issue_valid_i(issue_valid_i), .issue_waddr_i(issue_waddr_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .stall_o(stall1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          pend [2][32];
    int          waited;
    bit          mwe [2];
    logic [4:0]  maddr [2];
    logic [31:0] mdata [2];
    bit          model_ok = 0;

    function automatic logic [4:0] reg_of(input int k, input logic [4:0] a);
        return (k == 1) ? (a & 5'h0f) : a;
    endfunction

    function automatic bit model_ex_wins();
        return ex_valid_i && (!lsu_valid_i || waited >= LIMIT);
    endfunction

    function automatic bit model_stall(input int k);
        return pend[k][reg_of(k, raddr_a_i)] | pend[k][reg_of(k, raddr_b_i)];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst_i) begin
                for (int k = 0; k < 2; k++) begin
                    for (int r = 0; r < 32; r++) pend[k][r] = 0;
                    mwe[k] = 0; maddr[k] = 0; mdata[k] = 0;
                end
                waited   = 0;
                model_ok = 1;
            end else if (model_ok) begin
                bit ge, gl;
                ge = model_ex_wins();
                gl = lsu_valid_i && !ge;
                for (int k = 0; k < 2; k++) begin
                    if (mwe[k]) pend[k][maddr[k]] = 0;
                    if (issue_valid_i && reg_of(k, issue_waddr_i) != 0)
                        pend[k][reg_of(k, issue_waddr_i)] = 1;
                    if (ge) begin
                        maddr[k] = reg_of(k, ex_waddr_i); mdata[k] = ex_wdata_i;
                        mwe[k] = (maddr[k] != 0);
                    end else if (gl) begin
                        maddr[k] = reg_of(k, lsu_waddr_i); mdata[k] = lsu_wdata_i;
                        mwe[k] = (maddr[k] != 0);
                    end else begin
                        mwe[k] = 0;
                    end
                end
                if (ex_valid_i && !ge) waited = (waited + 1 > LIMIT) ? LIMIT : waited + 1;
                else waited = 0;
            end
        end
    end

    task automatic cmp_inst(input int k, input logic exr, input logic lsr, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd, input logic st);
        bit ge;
        ge = model_ex_wins();
        chk($sformatf("m%0d_ex_ready", k), {31'd0, exr}, {31'd0, ge});
        chk($sformatf("m%0d_lsu_ready", k), {31'd0, lsr}, {31'd0, lsu_valid_i && !ge});
        chk($sformatf("m%0d_rf_we", k), {31'd0, we}, {31'd0, mwe[k]});
        chk($sformatf("m%0d_rf_waddr", k), {27'd0, wa}, {27'd0, maddr[k]});
        chk($sformatf("m%0d_rf_wdata", k), wd, mdata[k]);
        chk($sformatf("m%0d_stall", k), {31'd0, st}, {31'd0, model_stall(k)});
    endtask

    // Compare process: every cycle once the model is synchronised by reset.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                cmp_inst(0, ex_ready0, lsu_ready0, we0, waddr0, wdata0, stall0);
                cmp_inst(1, ex_ready1, lsu_ready1, we1, waddr1, wdata1, stall1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    task automatic idle();
        ex_valid_i = 0; lsu_valid_i = 0; issue_valid_i = 0; rst_i = 0;
        ex_waddr_i = 0; lsu_waddr_i = 0; issue_waddr_i = 0;
        ex_wdata_i = 0; lsu_wdata_i = 0;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom);
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        raddr_a_i = 0; raddr_b_i = 0;
        rst_i = 1;
        nxt(); nxt();
        rst_i = 0;

        // Reset then idle
        for (int i = 0; i < 3; i++) begin
            raddr_a_i = 5'($urandom); raddr_b_i = 5'($urandom);
            smp();
            chk("idle_we", {31'd0, we0}, 0);
            chk("idle_stall", {31'd0, stall0 | stall1}, 0);
            chk("idle_ready", {30'd0, ex_ready0, lsu_ready0}, 0);
            chk("idle_waddr", {27'd0, waddr0}, 0);
            nxt();
        end
        raddr_a_i = 0; raddr_b_i = 0;

        // Single EX write
        ex_valid_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'hDEADBEEF;
        smp(); chk("ex1_ready", {31'd0, ex_ready0}, 1);
        nxt(); ex_valid_i = 0;
        smp();
        chk("ex1_we", {31'd0, we0}, 1);
        chk("ex1_waddr", {27'd0, waddr0}, 5);
        chk("ex1_wdata", wdata0, 32'hDEADBEEF);
        nxt(); smp(); chk("ex1_we_off", {31'd0, we0}, 0);
        nxt();

        // Contention and starvation
        ex_valid_i = 1; ex_waddr_i = 9; ex_wdata_i = 32'h9;
        lsu_valid_i = 1; lsu_waddr_i = 10; lsu_wdata_i = 32'hA;
        for (int c = 1; c <= 6; c++) begin
            smp();
            chk($sformatf("starve_c%0d_lsu", c), {31'd0, lsu_ready0}, (c == 5) ? 0 : 1);
            chk($sformatf("starve_c%0d_ex", c), {31'd0, ex_ready0}, (c == 5) ? 1 : 0);
            nxt();
            if (c == 5) ex_valid_i = 0;
            lsu_wdata_i = lsu_wdata_i + 1;
        end
        idle(); nxt(); nxt();

        // Scoreboard set and release
        issue_valid_i = 1; issue_waddr_i = 7; raddr_a_i = 7;
        smp(); chk("sb_c1_stall", {31'd0, stall0}, 0);
        nxt(); issue_valid_i = 0;
        smp(); chk("sb_c2_stall", {31'd0, stall0}, 1);
        nxt(); smp(); chk("sb_c3_stall", {31'd0, stall0}, 1);
        nxt(); lsu_valid_i = 1; lsu_waddr_i = 7; lsu_wdata_i = 32'h77;
        smp(); chk("sb_c4_lsu", {31'd0, lsu_ready0}, 1);
        nxt(); lsu_valid_i = 0;
        smp(); chk("sb_c5_we", {31'd0, we0}, 1); chk("sb_c5_stall", {31'd0, stall0}, 1);
        nxt(); smp(); chk("sb_c6_stall", {31'd0, stall0}, 0);
        nxt();

        // Set/clear collision
        issue_valid_i = 1; issue_waddr_i = 7;
        nxt(); issue_valid_i = 0; lsu_valid_i = 1; lsu_waddr_i = 7; lsu_wdata_i = 32'h1;
        nxt(); lsu_valid_i = 0; issue_valid_i = 1; issue_waddr_i = 7;
        smp(); chk("col_we", {31'd0, we0}, 1); chk("col_stall_a", {31'd0, stall0}, 1);
        nxt(); issue_valid_i = 0;
        smp(); chk("col_stall_b", {31'd0, stall0}, 1);
        nxt(); nxt(); smp(); chk("col_stall_c", {31'd0, stall0}, 1);
        nxt(); lsu_valid_i = 1; lsu_waddr_i = 7;
        nxt(); lsu_valid_i = 0;
        nxt(); smp(); chk("col_release", {31'd0, stall0}, 0);
        nxt();

        // Writes and issues to x0
        ex_valid_i = 1; ex_waddr_i = 0; ex_wdata_i = 32'h5555;
        issue_valid_i = 1; issue_waddr_i = 0; raddr_a_i = 0; raddr_b_i = 0;
        smp(); chk("x0_ready", {31'd0, ex_ready0}, 1);
        nxt(); idle();
        smp(); chk("x0_we", {31'd0, we0}, 0); chk("x0_stall", {31'd0, stall0 | stall1}, 0);
        nxt();

        // RV32E address folding
        issue_valid_i = 1; issue_waddr_i = 5'h13; raddr_a_i = 3;
        nxt(); issue_valid_i = 0;
        smp(); chk("e_stall_rv32e", {31'd0, stall1}, 1); chk("e_stall_rv32", {31'd0, stall0}, 0);
        nxt(); raddr_a_i = 5'h13; ex_valid_i = 1; ex_waddr_i = 5'h13; ex_wdata_i = 32'h13;
        smp(); chk("e_stall_both", {30'd0, stall0, stall1}, 2'b11);
        nxt(); ex_valid_i = 0;
        smp(); chk("e_waddr_rv32e", {27'd0, waddr1}, 3); chk("e_waddr_rv32", {27'd0, waddr0}, 5'h13);
        nxt(); smp(); chk("e_release", {30'd0, stall0, stall1}, 0);
        nxt();

        // Reset concurrent with a grant discards the write and the scoreboard
        issue_valid_i = 1; issue_waddr_i = 9; raddr_a_i = 9;
        nxt(); issue_valid_i = 0; ex_valid_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'h1234; rst_i = 1;
        smp(); chk("rst_ready", {31'd0, ex_ready0}, 1);
        nxt(); idle();
        smp(); chk("rst_we", {31'd0, we0}, 0); chk("rst_stall", {31'd0, stall0}, 0);
        chk("rst_wdata", wdata0, 0);
        nxt();

        // Randomised traffic respecting the valid/ready hold rule
        for (int i = 0; i < 3000; i++) begin
            bit ex_took, lsu_took;
            smp();
            ex_took  = ex_valid_i && ex_ready0;
            lsu_took = lsu_valid_i && lsu_ready0;
            nxt();
            if (!ex_valid_i || ex_took) begin
                ex_valid_i = ($urandom_range(0, 99) < 60);
                ex_waddr_i = rnd_addr(); ex_wdata_i = $urandom;
            end
            if (!lsu_valid_i || lsu_took) begin
                lsu_valid_i = ($urandom_range(0, 99) < 60);
                lsu_waddr_i = rnd_addr(); lsu_wdata_i = $urandom;
            end
            issue_valid_i = ($urandom_range(0, 99) < 30);
            issue_waddr_i = rnd_addr();
            raddr_a_i = rnd_addr(); raddr_b_i = rnd_addr();
            rst_i = ($urandom_range(0, 299) == 0);
        end
        idle();
        nxt(); smp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
